// File: rtl/eh2_ifu_scb_pkg.sv
// Shared types for the IFU expander scoreboard.
package eh2_ifu_scb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } scb_state_e;

  // Sticky protocol/completion flags; all cleared by start or reset.
  typedef struct packed {
    logic ovf;
    logic unf;
    logic tmo;
  } scb_flags_t;

  // Lane index width; one spare bit so LANES=1 still gets a 1-bit field.
  function automatic int unsigned lane_w(input int unsigned lanes);
    return $clog2(lanes) + 1;
  endfunction

endpackage

// File: rtl/eh2_ifu_scb_fifo.sv
// Single-lane expected-pair queue with synchronous clear.
module eh2_ifu_scb_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned W     = 48
) (
  input  logic         clk,
  input  logic         rst_l,
  input  logic         clr,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty,
  output logic         one
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   cnt_q;
  logic          do_push, do_pop;

  assign full    = (cnt_q == (AW+1)'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign one     = (cnt_q == (AW+1)'(1));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rptr_q];

  // Pointer and occupancy tracking; clear wins over push/pop.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else if (clr) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + AW'(1);
      if (do_pop)  rptr_q <= rptr_q + AW'(1);
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Storage array; contents are don't-care until the pointers cover them.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata;
  end

endmodule

// File: rtl/eh2_ifu_cmp_scoreboard.sv
// Multi-lane in-order expected/actual scoreboard for the IFU expander.
module eh2_ifu_cmp_scoreboard
  import eh2_ifu_scb_pkg::*;
#(
  parameter int unsigned LANES    = 2,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned CW       = 16,
  parameter int unsigned DW       = 32,
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned MAX_ERRS = 16,
  parameter int unsigned TMO      = 1024
) (
  input  logic                      clk,
  input  logic                      rst_l,
  input  logic                      start,
  input  logic                      eos,
  input  logic [LANES-1:0]          exp_valid,
  output logic [LANES-1:0]          exp_ready,
  input  logic [LANES*CW-1:0]       exp_cmp,
  input  logic [LANES*DW-1:0]       exp_data,
  input  logic [LANES-1:0]          act_valid,
  input  logic [LANES*DW-1:0]       act_data,
  output logic [LANES-1:0]          mismatch,
  output logic [CNT_W-1:0]          chk_cnt,
  output logic [CNT_W-1:0]          err_cnt,
  output logic                      fe_valid,
  output logic [lane_w(LANES)-1:0]  fe_lane,
  output logic [CNT_W-1:0]          fe_idx,
  output logic [CW-1:0]             fe_cmp,
  output logic [DW-1:0]             fe_exp,
  output logic [DW-1:0]             fe_act,
  output logic                      ovf_err,
  output logic                      unf_err,
  output logic                      done,
  output logic                      pass,
  output logic                      timeout
);

  localparam int unsigned LW = lane_w(LANES);
  localparam int unsigned TW = $clog2(TMO) + 1;

  typedef struct packed {
    logic [LW-1:0]    lane;
    logic [CNT_W-1:0] idx;
    logic [CW-1:0]    cmp;
    logic [DW-1:0]    exp;
    logic [DW-1:0]    act;
  } fe_rec_t;

  scb_state_e       state_q;
  scb_flags_t       flags_q, flags_d;
  fe_rec_t          fe_q, fe_d;
  logic             fe_valid_q, fe_valid_d;
  logic [CNT_W-1:0] chk_q, chk_d, err_q, err_d;
  logic [LANES-1:0] mis_q, mis_d;
  logic [TW-1:0]    tmo_q;
  logic [LW-1:0]    chk_inc, err_inc;
  logic [LANES-1:0] push, pop, full, empty, one;
  logic [CW+DW-1:0] head [LANES];
  logic             live, drained;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [LW-1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + (CNT_W+1)'(b);
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    eh2_ifu_scb_fifo #(.DEPTH(DEPTH), .W(CW + DW)) u_fifo (
      .clk   (clk),
      .rst_l (rst_l),
      .clr   (start),
      .push  (push[g]),
      .pop   (pop[g]),
      .wdata ({exp_cmp[g*CW +: CW], exp_data[g*DW +: DW]}),
      .rdata (head[g]),
      .full  (full[g]),
      .empty (empty[g]),
      .one   (one[g])
    );
  end

  // Per-lane push/pop gating, compare, popcount and first-error selection.
  // fe idx counts lower lanes popped this cycle so it matches serial order.
  always_comb begin
    live       = !start && (state_q == ST_RUN || state_q == ST_DRAIN);
    exp_ready  = '0;
    push       = '0;
    pop        = '0;
    chk_inc    = '0;
    err_inc    = '0;
    mis_d      = '0;
    fe_d       = fe_q;
    fe_valid_d = fe_valid_q;
    flags_d    = flags_q;
    drained    = 1'b1;
    for (int unsigned l = 0; l < LANES; l++) begin
      exp_ready[l] = (state_q == ST_RUN) && !full[l];
      push[l]      = exp_valid[l] && exp_ready[l];
      pop[l]       = live && act_valid[l] && !empty[l];
      if (pop[l]) begin
        if (act_data[l*DW +: DW] != head[l][DW-1:0]) begin
          mis_d[l] = 1'b1;
          err_inc  = err_inc + LW'(1);
          if (!fe_valid_d) begin
            fe_valid_d = 1'b1;
            fe_d.lane  = LW'(l);
            fe_d.idx   = sat_add(chk_q, chk_inc);
            fe_d.cmp   = head[l][CW+DW-1:DW];
            fe_d.exp   = head[l][DW-1:0];
            fe_d.act   = act_data[l*DW +: DW];
          end
        end
        chk_inc = chk_inc + LW'(1);
      end
      if (live && act_valid[l] && empty[l]) flags_d.unf = 1'b1;
      if (!start && state_q == ST_RUN && exp_valid[l] && full[l]) flags_d.ovf = 1'b1;
      if (!(empty[l] || (pop[l] && one[l]))) drained = 1'b0;
    end
    chk_d = sat_add(chk_q, chk_inc);
    err_d = sat_add(err_q, err_inc);
  end

  // Control FSM plus all registered status/records; start is a full restart.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q    <= ST_IDLE;
      chk_q      <= '0;
      err_q      <= '0;
      mis_q      <= '0;
      fe_valid_q <= 1'b0;
      fe_q       <= '0;
      flags_q    <= '0;
      tmo_q      <= '0;
    end else if (start) begin
      state_q    <= ST_RUN;
      chk_q      <= '0;
      err_q      <= '0;
      mis_q      <= '0;
      fe_valid_q <= 1'b0;
      fe_q       <= '0;
      flags_q    <= '0;
      tmo_q      <= '0;
    end else begin
      chk_q      <= chk_d;
      err_q      <= err_d;
      mis_q      <= mis_d;
      fe_valid_q <= fe_valid_d;
      fe_q       <= fe_d;
      flags_q    <= flags_d;
      unique case (state_q)
        ST_RUN: begin
          if (MAX_ERRS != 0 && err_d >= CNT_W'(MAX_ERRS)) begin
            state_q <= ST_DONE;
          end else if (eos) begin
            state_q <= ST_DRAIN;
            tmo_q   <= '0;
          end
        end
        ST_DRAIN: begin
          if (drained) begin
            state_q <= ST_DONE;
          end else if (tmo_q == TW'(TMO - 1)) begin
            state_q     <= ST_DONE;
            flags_q.tmo <= 1'b1;
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign mismatch = mis_q;
  assign chk_cnt  = chk_q;
  assign err_cnt  = err_q;
  assign fe_valid = fe_valid_q;
  assign fe_lane  = fe_q.lane;
  assign fe_idx   = fe_q.idx;
  assign fe_cmp   = fe_q.cmp;
  assign fe_exp   = fe_q.exp;
  assign fe_act   = fe_q.act;
  assign ovf_err  = flags_q.ovf;
  assign unf_err  = flags_q.unf;
  assign timeout  = flags_q.tmo;
  assign done     = (state_q == ST_DONE);
  assign pass     = done && (err_q == '0) && !flags_q.ovf && !flags_q.unf && !flags_q.tmo;

endmodule

// File: tb/tb_eh2_ifu_cmp_scoreboard.sv
// Directed bench for eh2_ifu_cmp_scoreboard (LANES=2, DEPTH=8, MAX_ERRS=4, TMO=16).
module tb_eh2_ifu_cmp_scoreboard;

  logic        clk = 1'b0;
  logic        rst_l;
  logic        start, eos;
  logic [1:0]  exp_valid, exp_ready, act_valid, mismatch;
  logic [31:0] exp_cmp;
  logic [63:0] exp_data, act_data;
  logic [31:0] chk_cnt, err_cnt, fe_idx;
  logic        fe_valid;
  logic [1:0]  fe_lane;
  logic [15:0] fe_cmp;
  logic [31:0] fe_exp, fe_act;
  logic        ovf_err, unf_err, done, pass, timeout;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  eh2_ifu_cmp_scoreboard #(
    .LANES(2), .DEPTH(8), .CW(16), .DW(32), .CNT_W(32), .MAX_ERRS(4), .TMO(16)
  ) dut (
    .clk(clk), .rst_l(rst_l), .start(start), .eos(eos),
    .exp_valid(exp_valid), .exp_ready(exp_ready), .exp_cmp(exp_cmp), .exp_data(exp_data),
    .act_valid(act_valid), .act_data(act_data), .mismatch(mismatch),
    .chk_cnt(chk_cnt), .err_cnt(err_cnt), .fe_valid(fe_valid), .fe_lane(fe_lane),
    .fe_idx(fe_idx), .fe_cmp(fe_cmp), .fe_exp(fe_exp), .fe_act(fe_act),
    .ovf_err(ovf_err), .unf_err(unf_err), .done(done), .pass(pass), .timeout(timeout)
  );

  function automatic logic [31:0] exp_of(input int l, input int k);
    if (l == 1 && k == 4) return 32'h00A0_0533;
    return {8'h5A, 8'(l), 16'(k)};
  endfunction

  function automatic logic [15:0] cmp_of(input int l, input int k);
    return 16'(16'h4000 + l * 256 + k);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_exp(input int l, input int k);
    exp_cmp[l*16 +: 16]  = cmp_of(l, k);
    exp_data[l*32 +: 32] = exp_of(l, k);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic check_all_zero(input string pfx);
    chk({pfx, "_exp_ready"}, 64'(exp_ready), 64'd0);
    chk({pfx, "_mismatch"}, 64'(mismatch), 64'd0);
    chk({pfx, "_chk_cnt"}, 64'(chk_cnt), 64'd0);
    chk({pfx, "_err_cnt"}, 64'(err_cnt), 64'd0);
    chk({pfx, "_fe"}, {fe_valid, fe_lane, fe_idx[28:0], fe_cmp, fe_exp[15:0]}, 64'd0);
    chk({pfx, "_fe_data"}, {fe_exp, fe_act}, 64'd0);
    chk({pfx, "_flags"}, 64'({ovf_err, unf_err, done, pass, timeout}), 64'd0);
  endtask

  initial begin
    rst_l = 1'b1; start = 1'b0; eos = 1'b0;
    exp_valid = '0; act_valid = '0; exp_cmp = '0; exp_data = '0; act_data = '0;
    #2 rst_l = 1'b0;
    #1 check_all_zero("reset");
    repeat (2) @(posedge clk);
    #2 rst_l = 1'b1;
    tick();
    chk("idle_ready", 64'(exp_ready), 64'd0);

    // Matching stream: 100 pairs per lane, actuals trail pushes by one cycle.
    pulse_start();
    chk("run_ready", 64'(exp_ready), 64'd3);
    for (int k = 0; k <= 100; k++) begin
      exp_valid = (k < 100) ? 2'b11 : 2'b00;
      if (k < 100) begin set_exp(0, k); set_exp(1, k); end
      act_valid = (k > 0) ? 2'b11 : 2'b00;
      if (k > 0) begin
        act_data[31:0]  = exp_of(0, k - 1);
        act_data[63:32] = exp_of(1, k - 1);
      end
      tick();
    end
    exp_valid = '0; act_valid = '0;
    chk("stream_chk_cnt", 64'(chk_cnt), 64'd200);
    eos = 1'b1; tick(); eos = 1'b0;
    chk("stream_drain_notdone", 64'(done), 64'd0);
    tick();
    chk("stream_done", 64'({done, pass, timeout}), 64'b110);
    chk("stream_err_cnt", 64'(err_cnt), 64'd0);
    chk("stream_fe_valid", 64'(fe_valid), 64'd0);
    chk("done_ready", 64'(exp_ready), 64'd0);

    // Single mismatch on lane 1, 5th pair, lanes checked alternately.
    pulse_start();
    chk("restart_cnt", 64'({chk_cnt, err_cnt}), 64'd0);
    chk("restart_done", 64'(done), 64'd0);
    for (int k = 0; k < 5; k++) begin
      exp_valid = 2'b11; set_exp(0, k); set_exp(1, k);
      tick();
    end
    exp_valid = '0;
    for (int i = 0; i < 10; i++) begin
      act_valid = 2'b01 << (i % 2);
      act_data[(i%2)*32 +: 32] = (i == 9) ? 32'h00A0_0534 : exp_of(i % 2, i / 2);
      tick();
      if (i == 8) chk("mis_pre_err", 64'({mismatch, err_cnt}), 64'd0);
    end
    act_valid = '0;
    chk("mis_pulse", 64'(mismatch), 64'd2);
    chk("mis_cnts", {chk_cnt, err_cnt}, {32'd10, 32'd1});
    chk("mis_fe_hdr", 64'({fe_valid, fe_lane, fe_idx}), {29'd0, 1'b1, 2'd1, 32'd9});
    chk("mis_fe_cmp", 64'(fe_cmp), 64'(cmp_of(1, 4)));
    chk("mis_fe_data", {fe_exp, fe_act}, {32'h00A0_0533, 32'h00A0_0534});
    tick();
    chk("mis_pulse_end", 64'(mismatch), 64'd0);
    eos = 1'b1; tick(); eos = 1'b0; tick();
    chk("mis_done", 64'({done, pass}), 64'b10);

    // Every compare fails: stop after four errors, no further pops.
    pulse_start();
    for (int k = 0; k < 6; k++) begin
      exp_valid = 2'b01; set_exp(0, k);
      tick();
    end
    exp_valid = '0;
    for (int i = 0; i < 6; i++) begin
      act_valid = 2'b01;
      act_data[31:0] = ~exp_of(0, i);
      tick();
      if (i == 3) begin
        chk("maxerr_err4", 64'(err_cnt), 64'd4);
        chk("maxerr_done", 64'({done, pass}), 64'b10);
      end
    end
    act_valid = '0;
    chk("maxerr_nopop", {chk_cnt, err_cnt}, {32'd4, 32'd4});
    chk("maxerr_quiet", 64'({mismatch, unf_err}), 64'd0);
    chk("maxerr_fe", 64'({fe_lane, fe_idx}), 64'd0);

    // Fill lane 0 to full, force a 9th push, then same-cycle push/pop on full.
    pulse_start();
    for (int k = 0; k < 8; k++) begin
      chk("fill_ready", 64'(exp_ready[0]), 64'd1);
      exp_valid = 2'b01; set_exp(0, k);
      tick();
    end
    chk("full_ready", 64'(exp_ready), 64'd2);
    chk("full_no_ovf", 64'(ovf_err), 64'd0);
    set_exp(0, 8);
    tick();
    chk("ovf_set", 64'({ovf_err, unf_err}), 64'b10);
    set_exp(0, 9);
    act_valid = 2'b01; act_data[31:0] = exp_of(0, 0);
    tick();
    exp_valid = '0;
    chk("fullpp_cnt", {chk_cnt, err_cnt}, {32'd1, 32'd0});
    chk("fullpp_ready", 64'(exp_ready[0]), 64'd1);
    act_valid = 2'b10; act_data[63:32] = 32'h1234_5678;
    tick();
    chk("unf_set", 64'(unf_err), 64'd1);
    chk("unf_chk_cnt", 64'(chk_cnt), 64'd1);
    act_valid = 2'b01; act_data[31:0] = exp_of(0, 1);
    tick();
    act_valid = '0;
    chk("order_after_full", 64'({mismatch, chk_cnt}), 64'd2);

    // Drain timeout with three entries left behind.
    pulse_start();
    for (int k = 0; k < 3; k++) begin
      exp_valid = 2'b01; set_exp(0, k);
      tick();
    end
    exp_valid = '0;
    eos = 1'b1; tick(); eos = 1'b0;
    repeat (15) tick();
    chk("tmo_not_yet", 64'({done, timeout}), 64'd0);
    tick();
    chk("tmo_done", 64'({done, pass, timeout}), 64'b101);
    chk("tmo_chk_cnt", 64'(chk_cnt), 64'd0);

    // Async reset in the middle of DRAIN wipes everything.
    pulse_start();
    for (int k = 0; k < 2; k++) begin
      exp_valid = 2'b01; set_exp(0, k);
      tick();
    end
    exp_valid = '0;
    act_valid = 2'b01; act_data[31:0] = 32'hDEAD_BEEF;
    tick();
    act_valid = '0;
    chk("prerst_err", 64'({fe_valid, err_cnt}), {31'd0, 1'b1, 32'd1});
    eos = 1'b1; tick(); eos = 1'b0;
    repeat (3) tick();
    chk("prerst_draining", 64'(done), 64'd0);
    #2 rst_l = 1'b0;
    #1 check_all_zero("midrst");
    @(negedge clk);
    rst_l = 1'b1;
    tick();
    chk("postrst_idle", 64'({exp_ready, done}), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
